lfsr_feeder: RTL

LFSR_FEEDER -- requirements
Module: lfsr_feeder

---
 rtl/lfsr_feeder_pkg.sv | 21 ++
 rtl/lfsr_feeder_gearbox.sv | 66 ++++++
 rtl/lfsr_feeder.sv | 86 ++++++++
 3 files changed

// File: rtl/lfsr_feeder_pkg.sv
// Shared definitions for the LFSR feeder: FSM states and default widths.
package lfsr_feeder_pkg;

    localparam int unsigned STATE_W_DEF = 347;
    localparam int unsigned STEP_W_DEF  = 11;

    // The gearbox holds one full step plus up to seven leftover bits of a byte.
    function automatic int unsigned buf_width(input int unsigned step_w);
        return step_w + 7;
    endfunction

    localparam int unsigned BUF_W_DEF = STEP_W_DEF + 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } fsm_e;

endpackage

// File: rtl/lfsr_feeder_gearbox.sv
// 8-to-STEP_W bit gearbox: appends accepted bytes, emits STEP_W-bit chunks,
// and zero-pads the final partial chunk while flushing.
module lfsr_feeder_gearbox
    import lfsr_feeder_pkg::*;
#(
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              run_i,
    input  logic              flush_i,
    input  logic              accept_i,
    input  logic [7:0]        data_i,
    output logic [STEP_W-1:0] bits_o,
    output logic              step_o,
    output logic              empty_o
);

    localparam int unsigned BUF_W = buf_width(STEP_W);
    localparam int unsigned CW    = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] bits_q, bits_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_sh;
    logic             full_step, pad_step;

    // Bits at and above cnt_q are always zero, so a pad step needs no masking.
    always_comb begin
        full_step = run_i && (cnt_q >= CW'(STEP_W));
        pad_step  = flush_i && (cnt_q != '0) && (cnt_q < CW'(STEP_W));
        shifted   = bits_q;
        cnt_sh    = cnt_q;
        if (full_step) begin
            shifted = bits_q >> STEP_W;
            cnt_sh  = cnt_q - CW'(STEP_W);
        end else if (pad_step) begin
            shifted = '0;
            cnt_sh  = '0;
        end
        bits_d = shifted;
        cnt_d  = cnt_sh;
        if (accept_i) begin
            bits_d = shifted | (BUF_W'(data_i) << cnt_sh);
            cnt_d  = cnt_sh + CW'(8);
        end
        if (clear_i) begin
            bits_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bits_o  = bits_q[STEP_W-1:0];
    assign step_o  = full_step || pad_step;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/lfsr_feeder.sv
// Feeds a byte stream into an external STEP_W-bit scrambler step stage and
// reports the final scrambler state as a signature per message.
module lfsr_feeder
    import lfsr_feeder_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEF,
    parameter int unsigned STEP_W  = STEP_W_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] seed,
    input  logic               seed_load,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [STATE_W-1:0] lfsr_state,
    output logic [STEP_W-1:0]  lfsr_bits,
    input  logic [STATE_W-1:0] lfsr_next,
    output logic               sig_valid,
    output logic [STATE_W-1:0] sig,
    output logic [CNT_W-1:0]   step_cnt
);

    fsm_e               state_q, state_d;
    logic [STATE_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               start, accept, step, empty;

    lfsr_feeder_gearbox #(
        .STEP_W(STEP_W)
    ) u_gearbox (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start),
        .run_i   ((state_q == ST_RUN) || (state_q == ST_FLUSH)),
        .flush_i (state_q == ST_FLUSH),
        .accept_i(accept),
        .data_i  (in_data),
        .bits_o  (lfsr_bits),
        .step_o  (step),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        start   = (state_q == ST_IDLE) && seed_load;
        accept  = (state_q == ST_RUN) && in_valid;
        case (state_q)
            ST_IDLE:  if (seed_load) state_d = ST_RUN;
            ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH: if (empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        lfsr_d  = lfsr_q;
        steps_d = steps_q;
        if (start) begin
            lfsr_d  = seed;
            steps_d = '0;
        end else if (step) begin
            lfsr_d  = lfsr_next;
            steps_d = steps_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            steps_q <= steps_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign sig_valid  = (state_q == ST_DONE);
    assign sig        = sig_valid ? lfsr_q : '0;
    assign lfsr_state = lfsr_q;
    assign step_cnt   = steps_q;

endmodule
